// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit five-stage core's hazard/interrupt logic:
//   REG_NONE            register index meaning "no register"
//   PC_SEQ/BRANCH/VECTOR 2-bit PC select codes
//   int_state_t         interrupt sequencer states (IDLE, DRAIN, SAVE, VECTOR)
//   *_DEF               default values for the hazard_ctrl parameters
//   srcHit()            register match helper that never matches REG_NONE
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [3:0]  REG_NONE         = 4'hF;

  localparam logic [1:0]  PC_SEQ           = 2'b00;
  localparam logic [1:0]  PC_BRANCH        = 2'b01;
  localparam logic [1:0]  PC_VECTOR        = 2'b10;

  localparam logic [15:0] INT_VECTOR_DEF   = 16'h0008;
  localparam logic [15:0] IMEM_TOP_DEF     = 16'h7FFF;
  localparam int          DRAIN_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SAVE   = 2'd2,
    VECTOR = 2'd3
  } int_state_t;

  // True when the producing destination feeds this source. An index of
  // REG_NONE on either side means "no register" and can never match.
  function automatic logic srcHit(input logic [3:0] dst, input logic [3:0] src);
    return (dst != REG_NONE) && (src != REG_NONE) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles the pipeline-side signals of the hazard controller.
//   master : pipeline side (drives stage info, receives stall/flush/PC control)
//   slave  : hazard_ctrl side
// Pipeline inputs : idex_memread_i, idex_regdst_i, idex_epc_i, ifid_regsrc1_i,
//                   ifid_regsrc2_i, exmem_memwrite_i, exmem_addr_i,
//                   branch_taken_i, branch_target_i, int_req_i
// Control outputs : pc_stall_o, ifid_stall_o, flush_if_o, flush_id_o,
//                   pc_sel_o, pc_target_o, epc_save_o, epc_o, int_ack_o,
//                   busy_o, and stall_cnt_o when HAZARD_STALL_CNT_EN is defined
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;

  logic        idex_memread_i;
  logic [3:0]  idex_regdst_i;
  logic [15:0] idex_epc_i;
  logic [3:0]  ifid_regsrc1_i;
  logic [3:0]  ifid_regsrc2_i;
  logic        exmem_memwrite_i;
  logic [15:0] exmem_addr_i;
  logic        branch_taken_i;
  logic [15:0] branch_target_i;
  logic        int_req_i;

  logic        pc_stall_o;
  logic        ifid_stall_o;
  logic        flush_if_o;
  logic        flush_id_o;
  logic [1:0]  pc_sel_o;
  logic [15:0] pc_target_o;
  logic        epc_save_o;
  logic [15:0] epc_o;
  logic        int_ack_o;
  logic        busy_o;
`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  modport master (
    output idex_memread_i, idex_regdst_i, idex_epc_i,
           ifid_regsrc1_i, ifid_regsrc2_i,
           exmem_memwrite_i, exmem_addr_i,
           branch_taken_i, branch_target_i, int_req_i,
    input  pc_stall_o, ifid_stall_o, flush_if_o, flush_id_o,
           pc_sel_o, pc_target_o, epc_save_o, epc_o, int_ack_o, busy_o
`ifdef HAZARD_STALL_CNT_EN
         , stall_cnt_o
`endif
  );

  modport slave (
    input  idex_memread_i, idex_regdst_i, idex_epc_i,
           ifid_regsrc1_i, ifid_regsrc2_i,
           exmem_memwrite_i, exmem_addr_i,
           branch_taken_i, branch_target_i, int_req_i,
    output pc_stall_o, ifid_stall_o, flush_if_o, flush_id_o,
           pc_sel_o, pc_target_o, epc_save_o, epc_o, int_ack_o, busy_o
`ifdef HAZARD_STALL_CNT_EN
         , stall_cnt_o
`endif
  );

endinterface

// File: rtl/hazard_ctrl_int_seq.sv
// ---------------------------------------------------------------------------
// int_seq
// Interrupt entry sequencer: IDLE -> DRAIN (DRAIN_CYCLES cycles) -> SAVE ->
// VECTOR -> IDLE. Captures the ID/EX epc on the entry edge.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   i_intReq        level interrupt request (only looked at in IDLE)
//   i_branchTaken   a taken branch this cycle defers interrupt entry
//   i_epc           ID/EX epc to capture on entry
//   o_state         current sequencer state
//   o_epc           captured EPC
// ---------------------------------------------------------------------------
module int_seq
  import cpu_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_intReq,
  input  logic        i_branchTaken,
  input  logic [15:0] i_epc,
  output int_state_t  o_state,
  output logic [15:0] o_epc
);

  // Drain counter value on the last drain cycle.
  localparam logic [2:0] LAST_CNT = 3'(DRAIN_CYCLES - 1);

  int_state_t  r_state;
  int_state_t  w_nextState;
  logic [2:0]  r_drainCnt;
  logic [2:0]  w_nextCnt;
  logic [15:0] r_epc;
  logic [15:0] w_nextEpc;

  // State, drain counter and EPC registers. Reset drops any sequence in
  // progress back to IDLE so no save or ack strobe follows.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_drainCnt <= '0;
      r_epc      <= '0;
    end else begin
      r_state    <= w_nextState;
      r_drainCnt <= w_nextCnt;
      r_epc      <= w_nextEpc;
    end
  end

  // Next-state logic. A taken branch in the request cycle wins: the redirect
  // is honoured first and entry happens on a later cycle if the request is
  // still high. The counter runs only while draining and is cleared on exit
  // so the next entry starts from zero.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_drainCnt;
    w_nextEpc   = r_epc;
    case (r_state)
      IDLE: begin
        if (i_intReq && !i_branchTaken) begin
          w_nextState = DRAIN;
          w_nextCnt   = '0;
          w_nextEpc   = i_epc;
        end
      end
      DRAIN: begin
        if (r_drainCnt == LAST_CNT) begin
          w_nextState = SAVE;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt   = r_drainCnt + 3'd1;
        end
      end
      SAVE:    w_nextState = VECTOR;
      VECTOR:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  assign o_state = r_state;
  assign o_epc   = r_epc;

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard and interrupt sequencer for the 16-bit five-stage core.
// Detects load-use and store-vs-fetch structural hazards, applies branch
// redirects and sequences interrupt entry through int_seq.
// Ports:
//   CLK   core clock, rising edge
//   RST   synchronous active-high reset
//   bus   hazard_ctrl_if.slave (stage info in, stall/flush/PC control out)
// Optional feature: HAZARD_STALL_CNT_EN adds bus.stall_cnt_o, a saturating
// count of cycles with pc_stall_o high.
// ---------------------------------------------------------------------------
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter logic [15:0] INT_VECTOR   = INT_VECTOR_DEF,
  parameter logic [15:0] IMEM_TOP     = IMEM_TOP_DEF,
  parameter int          DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  hazard_ctrl_if.slave bus
);

  int_state_t  w_state;
  logic [15:0] w_epc;
  logic        w_loadUse;
  logic        w_struct;

  logic        w_pcStall;
  logic        w_ifidStall;
  logic        w_flushIf;
  logic        w_flushId;
  logic [1:0]  w_pcSel;
  logic [15:0] w_pcTarget;
  logic        w_epcSave;
  logic        w_intAck;
  logic        w_busy;

  int_seq #(
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) u_intSeq (
    .CLK           (CLK),
    .RST           (RST),
    .i_intReq      (bus.int_req_i),
    .i_branchTaken (bus.branch_taken_i),
    .i_epc         (bus.idex_epc_i),
    .o_state       (w_state),
    .o_epc         (w_epc)
  );

  assign w_loadUse = bus.idex_memread_i &&
                     (srcHit(bus.idex_regdst_i, bus.ifid_regsrc1_i) ||
                      srcHit(bus.idex_regdst_i, bus.ifid_regsrc2_i));

  assign w_struct  = bus.exmem_memwrite_i && (bus.exmem_addr_i <= IMEM_TOP);

  // Priority mux: reset, then the interrupt sequence, then branch, then the
  // OR of structural and load-use. A taken branch kills the ID instruction so
  // its load-use stall is dropped. When both stalls coincide the IF bubble is
  // withheld because IF/ID is being held, not refilled.
  always_comb begin
    w_pcStall   = 1'b0;
    w_ifidStall = 1'b0;
    w_flushIf   = 1'b0;
    w_flushId   = 1'b0;
    w_pcSel     = PC_SEQ;
    w_pcTarget  = 16'h0000;
    w_epcSave   = 1'b0;
    w_intAck    = 1'b0;
    w_busy      = 1'b0;
    if (!RST) begin
      case (w_state)
        IDLE: begin
          if (bus.branch_taken_i) begin
            w_flushIf  = 1'b1;
            w_flushId  = 1'b1;
            w_pcSel    = PC_BRANCH;
            w_pcTarget = bus.branch_target_i;
          end else begin
            if (w_struct) begin
              w_pcStall = 1'b1;
              w_flushIf = 1'b1;
            end
            if (w_loadUse) begin
              w_pcStall   = 1'b1;
              w_ifidStall = 1'b1;
              w_flushId   = 1'b1;
              w_flushIf   = 1'b0;
            end
          end
        end
        DRAIN: begin
          w_pcStall = 1'b1;
          w_flushIf = 1'b1;
          w_flushId = 1'b1;
          w_busy    = 1'b1;
        end
        SAVE: begin
          w_pcStall = 1'b1;
          w_flushIf = 1'b1;
          w_flushId = 1'b1;
          w_epcSave = 1'b1;
          w_busy    = 1'b1;
        end
        VECTOR: begin
          w_pcSel    = PC_VECTOR;
          w_pcTarget = INT_VECTOR;
          w_intAck   = 1'b1;
          w_flushIf  = 1'b1;
          w_busy     = 1'b1;
        end
        default: begin
          w_busy = 1'b1;
        end
      endcase
    end
  end

  assign bus.pc_stall_o   = w_pcStall;
  assign bus.ifid_stall_o = w_ifidStall;
  assign bus.flush_if_o   = w_flushIf;
  assign bus.flush_id_o   = w_flushId;
  assign bus.pc_sel_o     = w_pcSel;
  assign bus.pc_target_o  = w_pcTarget;
  assign bus.epc_save_o   = w_epcSave;
  assign bus.epc_o        = w_epc;
  assign bus.int_ack_o    = w_intAck;
  assign bus.busy_o       = w_busy;

`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] r_stallCnt;

  // Saturating count of PC stall cycles for performance monitoring.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stallCnt <= '0;
    end else if (w_pcStall && (r_stallCnt != 16'hFFFF)) begin
      r_stallCnt <= r_stallCnt + 16'd1;
    end
  end

  assign bus.stall_cnt_o = r_stallCnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. Each step drives one cycle of pipeline
// inputs, pushes the outputs expected for that cycle onto a scoreboard and
// pops/compares them later in the same cycle, well away from the clock edge.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
  import cpu_pkg::*;

  typedef struct packed {
    logic        rst;
    logic        memread;
    logic [3:0]  regdst;
    logic [15:0] epc;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        memwrite;
    logic [15:0] addr;
    logic        brTaken;
    logic [15:0] brTarget;
    logic        intReq;
  } stim_t;

  typedef struct {
    string       tag;
    logic [40:0] value;
  } exp_t;

  logic CLK;
  logic RST;
  int   nChecks;
  int   nErrors;
  exp_t scoreboard[$];

  hazard_ctrl_if bus ();

  hazard_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // 10-unit clock period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Quiet pipeline: no load, no store, no branch, no request.
  function automatic stim_t idleStim();
    stim_t s;
    s.rst      = 1'b0;
    s.memread  = 1'b0;
    s.regdst   = REG_NONE;
    s.epc      = 16'h0000;
    s.src1     = REG_NONE;
    s.src2     = REG_NONE;
    s.memwrite = 1'b0;
    s.addr     = 16'h0000;
    s.brTaken  = 1'b0;
    s.brTarget = 16'h0000;
    s.intReq   = 1'b0;
    return s;
  endfunction

  // Packs one cycle of expected outputs in the same order checkOutput samples.
  function automatic logic [40:0] mkExp(
    input logic pcStall, input logic ifidStall, input logic flushIf,
    input logic flushId, input logic [1:0] pcSel, input logic [15:0] target,
    input logic epcSave, input logic [15:0] epc, input logic ack,
    input logic busy);
    return {pcStall, ifidStall, flushIf, flushId, pcSel, target,
            epcSave, epc, ack, busy};
  endfunction

  // Drives one cycle of inputs just after the rising edge and queues the
  // outputs expected for that cycle.
  task automatic applyStimulus(input string tag, input stim_t s,
                               input logic [40:0] expected);
    exp_t e;
    @(posedge CLK);
    #1;
    RST                  = s.rst;
    bus.idex_memread_i   = s.memread;
    bus.idex_regdst_i    = s.regdst;
    bus.idex_epc_i       = s.epc;
    bus.ifid_regsrc1_i   = s.src1;
    bus.ifid_regsrc2_i   = s.src2;
    bus.exmem_memwrite_i = s.memwrite;
    bus.exmem_addr_i     = s.addr;
    bus.branch_taken_i   = s.brTaken;
    bus.branch_target_i  = s.brTarget;
    bus.int_req_i        = s.intReq;
    e.tag   = tag;
    e.value = expected;
    scoreboard.push_back(e);
  endtask

  // Samples the outputs mid-cycle and compares against the oldest queued
  // expectation.
  task automatic checkOutput();
    exp_t        e;
    logic [40:0] obs;
    #3;
    obs = {bus.pc_stall_o, bus.ifid_stall_o, bus.flush_if_o, bus.flush_id_o,
           bus.pc_sel_o, bus.pc_target_o, bus.epc_save_o, bus.epc_o,
           bus.int_ack_o, bus.busy_o};
    nChecks++;
    assert (scoreboard.size() != 0) else begin
      nErrors++;
      $error("[TB] FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end
    if (scoreboard.size() != 0) begin
      e = scoreboard.pop_front();
      assert (obs === e.value) else begin
        nErrors++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.value);
      end
    end
  endtask

  task automatic runStep(input string tag, input stim_t s,
                         input logic [40:0] expected);
    applyStimulus(tag, s, expected);
    checkOutput();
  endtask

  // Directed sequence: reset, load-use, structural, branch priority, a full
  // interrupt entry, interrupt deferred by a branch, and reset mid-drain.
  initial begin
    stim_t s;
    nChecks = 0;
    nErrors = 0;

    s = idleStim();
    RST                  = 1'b1;
    bus.idex_memread_i   = s.memread;
    bus.idex_regdst_i    = s.regdst;
    bus.idex_epc_i       = s.epc;
    bus.ifid_regsrc1_i   = s.src1;
    bus.ifid_regsrc2_i   = s.src2;
    bus.exmem_memwrite_i = s.memwrite;
    bus.exmem_addr_i     = s.addr;
    bus.branch_taken_i   = s.brTaken;
    bus.branch_target_i  = s.brTarget;
    bus.int_req_i        = s.intReq;
    repeat (2) @(posedge CLK);
    $display("[TB] reset applied");

    // Reset masks a live load-use hazard.
    s = idleStim(); s.rst = 1'b1;
    s.memread = 1'b1; s.regdst = 4'h3; s.src1 = 4'h3;
    runStep("reset_hold", s, mkExp(0,0,0,0,PC_SEQ,16'h0000,0,16'h0000,0,0));

    s = idleStim();
    runStep("idle", s, mkExp(0,0,0,0,PC_SEQ,16'h0000,0,16'h0000,0,0));

    // Load-use hazards.
    s = idleStim(); s.memread = 1'b1; s.regdst = 4'h3; s.src1 = 4'h3;
    runStep("loaduse_src1", s, mkExp(1,1,0,1,PC_SEQ,16'h0000,0,16'h0000,0,0));
    s = idleStim(); s.memread = 1'b1; s.regdst = 4'h5; s.src2 = 4'h5;
    runStep("loaduse_src2", s, mkExp(1,1,0,1,PC_SEQ,16'h0000,0,16'h0000,0,0));
    s = idleStim(); s.memread = 1'b1;
    runStep("loaduse_none", s, mkExp(0,0,0,0,PC_SEQ,16'h0000,0,16'h0000,0,0));
    s = idleStim(); s.memread = 1'b1; s.regdst = 4'h3; s.src1 = 4'h4; s.src2 = 4'h5;
    runStep("loaduse_miss", s, mkExp(0,0,0,0,PC_SEQ,16'h0000,0,16'h0000,0,0));
    s = idleStim(); s.regdst = 4'h3; s.src1 = 4'h3;
    runStep("no_memread", s, mkExp(0,0,0,0,PC_SEQ,16'h0000,0,16'h0000,0,0));

    // Structural store-vs-fetch hazards around the instruction-region top.
    s = idleStim(); s.memwrite = 1'b1; s.addr = 16'h4000;
    runStep("struct_low", s, mkExp(1,0,1,0,PC_SEQ,16'h0000,0,16'h0000,0,0));
    s = idleStim(); s.memwrite = 1'b1; s.addr = 16'h7FFF;
    runStep("struct_top", s, mkExp(1,0,1,0,PC_SEQ,16'h0000,0,16'h0000,0,0));
    s = idleStim(); s.memwrite = 1'b1; s.addr = 16'h8000;
    runStep("struct_high", s, mkExp(0,0,0,0,PC_SEQ,16'h0000,0,16'h0000,0,0));
    s = idleStim(); s.memwrite = 1'b1; s.addr = 16'h4000;
    s.memread = 1'b1; s.regdst = 4'h2; s.src2 = 4'h2;
    runStep("struct_loaduse", s, mkExp(1,1,0,1,PC_SEQ,16'h0000,0,16'h0000,0,0));

    // Branch wins over the data hazards.
    s = idleStim(); s.brTaken = 1'b1; s.brTarget = 16'h0123;
    s.memread = 1'b1; s.regdst = 4'h3; s.src1 = 4'h3;
    runStep("branch_loaduse", s, mkExp(0,0,1,1,PC_BRANCH,16'h0123,0,16'h0000,0,0));
    s = idleStim(); s.brTaken = 1'b1; s.brTarget = 16'h0456;
    s.memwrite = 1'b1; s.addr = 16'h4000;
    runStep("branch_struct", s, mkExp(0,0,1,1,PC_BRANCH,16'h0456,0,16'h0000,0,0));

    // Interrupt entry: request cycle, two drain cycles, save, vector.
    s = idleStim(); s.intReq = 1'b1; s.epc = 16'h0042;
    runStep("int_req", s, mkExp(0,0,0,0,PC_SEQ,16'h0000,0,16'h0000,0,0));
    s = idleStim(); s.epc = 16'h1111;
    s.memread = 1'b1; s.regdst = 4'h3; s.src1 = 4'h3;
    runStep("int_drain1", s, mkExp(1,0,1,1,PC_SEQ,16'h0000,0,16'h0042,0,1));
    s = idleStim(); s.intReq = 1'b1; s.brTaken = 1'b1; s.brTarget = 16'h0999;
    runStep("int_drain2", s, mkExp(1,0,1,1,PC_SEQ,16'h0000,0,16'h0042,0,1));
    s = idleStim(); s.intReq = 1'b1;
    runStep("int_save", s, mkExp(1,0,1,1,PC_SEQ,16'h0000,1,16'h0042,0,1));
    s = idleStim();
    runStep("int_vector", s, mkExp(0,0,1,0,PC_VECTOR,16'h0008,0,16'h0042,1,1));
    s = idleStim();
    runStep("int_done", s, mkExp(0,0,0,0,PC_SEQ,16'h0000,0,16'h0042,0,0));

    // Request with a taken branch: redirect first, entry one cycle later.
    s = idleStim(); s.intReq = 1'b1; s.epc = 16'h0077;
    s.brTaken = 1'b1; s.brTarget = 16'h0200;
    runStep("int_with_branch", s, mkExp(0,0,1,1,PC_BRANCH,16'h0200,0,16'h0042,0,0));
    s = idleStim(); s.intReq = 1'b1; s.epc = 16'h0088;
    runStep("int_after_branch", s, mkExp(0,0,0,0,PC_SEQ,16'h0000,0,16'h0042,0,0));
    s = idleStim();
    runStep("int2_drain1", s, mkExp(1,0,1,1,PC_SEQ,16'h0000,0,16'h0088,0,1));

    // Reset in the middle of draining aborts the entry.
    s = idleStim(); s.rst = 1'b1;
    runStep("reset_in_drain", s, mkExp(0,0,0,0,PC_SEQ,16'h0000,0,16'h0088,0,0));
    s = idleStim();
    runStep("after_reset", s, mkExp(0,0,0,0,PC_SEQ,16'h0000,0,16'h0000,0,0));
    for (int i = 0; i < 4; i++) begin
      runStep("after_reset_quiet", s, mkExp(0,0,0,0,PC_SEQ,16'h0000,0,16'h0000,0,0));
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
